// File: rtl/odd_seq_checker.sv
// Receive-side monitor for the odd counter stream: locks onto the +STEP sequence
// and flags sequence misses, even samples and loss of lock.
module odd_seq_checker #(
  parameter int WIDTH      = 8,
  parameter int STEP       = 2,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 2,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] cnt_i,
  output logic             locked_o,
  output logic             err_o,
  output logic             parity_err_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [WIDTH-1:0] exp_o
);

  localparam int RUN_W  = (LOCK_CNT   < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int MISS_W = (UNLOCK_CNT < 1) ? 1 : $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [WIDTH-1:0]    exp_q, exp_n;
  logic [RUN_W-1:0]    run, run_n;
  logic [MISS_W-1:0]   miss, miss_n;
  logic [ERR_W-1:0]    err_cnt, err_cnt_n;
  logic                locked_n, err_n, parity_n;
  logic                match, odd;
  logic [WIDTH-1:0]    anchor;

  assign match  = (cnt_i == exp_q);
  assign odd    = cnt_i[0];
  assign anchor = cnt_i + WIDTH'(STEP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= HUNT;
      exp_q        <= WIDTH'(1);
      run          <= '0;
      miss         <= '0;
      err_cnt      <= '0;
      locked_o     <= 1'b0;
      err_o        <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      state        <= state_n;
      exp_q        <= exp_n;
      run          <= run_n;
      miss         <= miss_n;
      err_cnt      <= err_cnt_n;
      locked_o     <= locked_n;
      err_o        <= err_n;
      parity_err_o <= parity_n;
    end
  end

  // Every accepted sample outside HUNT re-anchors the expectation, matched or not.
  always_comb begin
    state_n   = state;
    exp_n     = exp_q;
    run_n     = run;
    miss_n    = miss;
    err_cnt_n = err_cnt;
    err_n     = 1'b0;
    parity_n  = 1'b0;
    if (valid_i) begin
      parity_n = ~odd;
      case (state)
        HUNT: begin
          if (odd) begin
            exp_n   = anchor;
            run_n   = '0;
            state_n = SYNC;
          end
        end
        SYNC: begin
          exp_n = anchor;
          if (!odd) begin
            state_n = HUNT;
            run_n   = '0;
          end else if (match) begin
            if (run == RUN_W'(LOCK_CNT - 1)) begin
              state_n = LOCK;
              run_n   = '0;
              miss_n  = '0;
            end else begin
              run_n = run + RUN_W'(1);
            end
          end else begin
            run_n = '0;
          end
        end
        LOCK: begin
          exp_n = anchor;
          if (match && odd) begin
            miss_n = '0;
          end else begin
            err_n = 1'b1;
            if (err_cnt != '1) err_cnt_n = err_cnt + ERR_W'(1);
            if (miss == MISS_W'(UNLOCK_CNT - 1)) begin
              state_n = HUNT;
              miss_n  = '0;
            end else begin
              miss_n = miss + MISS_W'(1);
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
    locked_n = (state_n == LOCK);
  end

  assign err_cnt_o = err_cnt;
  assign exp_o     = exp_q;

endmodule

// File: tb/tb_odd_seq_checker.sv
// Self-checking bench for odd_seq_checker: directed lock/wrap/glitch/unlock/reset
// scenarios followed by random traffic, checked against a behavioural model.
module tb_odd_seq_checker;

  localparam int WIDTH      = 8;
  localparam int STEP       = 2;
  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_CNT = 2;
  localparam int ERR_W      = 16;
  localparam int SAT_W      = 2;

  localparam int P_HUNT = 0;
  localparam int P_SYNC = 1;
  localparam int P_LOCK = 2;

  logic             clk;
  logic             reset;
  logic             valid_i;
  logic [WIDTH-1:0] cnt_i;
  logic             locked_o, err_o, parity_err_o;
  logic [ERR_W-1:0] err_cnt_o;
  logic [WIDTH-1:0] exp_o;
  logic             locked2, err2, parity2;
  logic [SAT_W-1:0] err_cnt2;
  logic [WIDTH-1:0] exp2;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_phase, m_exp, m_run, m_miss, m_errs;
  bit m_err, m_par;

  odd_seq_checker #(.WIDTH(WIDTH), .STEP(STEP), .LOCK_CNT(LOCK_CNT),
                    .UNLOCK_CNT(UNLOCK_CNT), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .cnt_i(cnt_i),
    .locked_o(locked_o), .err_o(err_o), .parity_err_o(parity_err_o),
    .err_cnt_o(err_cnt_o), .exp_o(exp_o)
  );

  // Narrow error counter copy so saturation is reachable in a few events.
  odd_seq_checker #(.WIDTH(WIDTH), .STEP(STEP), .LOCK_CNT(LOCK_CNT),
                    .UNLOCK_CNT(UNLOCK_CNT), .ERR_W(SAT_W)) dut_sat (
    .clk(clk), .reset(reset), .valid_i(valid_i), .cnt_i(cnt_i),
    .locked_o(locked2), .err_o(err2), .parity_err_o(parity2),
    .err_cnt_o(err_cnt2), .exp_o(exp2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_phase = P_HUNT; m_exp = 1; m_run = 0; m_miss = 0; m_errs = 0;
    m_err = 0; m_par = 0;
  endtask

  task automatic model_sample(input bit v, input int c);
    bit is_odd, hit;
    m_err = 0; m_par = 0;
    if (!v) return;
    is_odd = (c % 2) == 1;
    hit    = (c == m_exp);
    m_par  = !is_odd;
    if (m_phase == P_HUNT) begin
      if (is_odd) begin
        m_exp = (c + STEP) % 256; m_run = 0; m_phase = P_SYNC;
      end
    end else if (m_phase == P_SYNC) begin
      m_exp = (c + STEP) % 256;
      if (!is_odd) begin
        m_phase = P_HUNT;
      end else if (hit) begin
        m_run = m_run + 1;
        if (m_run >= LOCK_CNT) begin m_phase = P_LOCK; m_miss = 0; end
      end else begin
        m_run = 0;
      end
    end else begin
      m_exp = (c + STEP) % 256;
      if (hit && is_odd) begin
        m_miss = 0;
      end else begin
        m_err = 1; m_errs++; m_miss++;
        if (m_miss >= UNLOCK_CNT) begin m_phase = P_HUNT; m_miss = 0; m_run = 0; end
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    int sat_full, sat_small;
    sat_full  = (m_errs > 65535) ? 65535 : m_errs;
    sat_small = (m_errs > 3) ? 3 : m_errs;
    check({tag, ".locked"}, 32'(locked_o), 32'(m_phase == P_LOCK));
    check({tag, ".err"}, 32'(err_o), 32'(m_err));
    check({tag, ".parity"}, 32'(parity_err_o), 32'(m_par));
    check({tag, ".err_cnt"}, 32'(err_cnt_o), 32'(sat_full));
    check({tag, ".exp"}, 32'(exp_o), 32'(m_exp));
    check({tag, ".err_cnt_sat"}, 32'(err_cnt2), 32'(sat_small));
  endtask

  task automatic applyStimulus(input bit v, input int c);
    @(negedge clk);
    reset   = 1'b0;
    valid_i = v;
    cnt_i   = WIDTH'(c);
    @(posedge clk);
    #1;
    model_sample(v, c);
  endtask

  task automatic applyReset(input bit v, input int c);
    @(negedge clk);
    reset   = 1'b1;
    valid_i = v;
    cnt_i   = WIDTH'(c);
    @(posedge clk);
    #1;
    model_reset();
    checkOutput("reset");
  endtask

  task automatic stepc(input string tag, input bit v, input int c);
    applyStimulus(v, c);
    checkOutput(tag);
  endtask

  initial begin
    int c, r;
    bit v;
    reset = 1'b1; valid_i = 1'b0; cnt_i = '0;
    model_reset();
    applyReset(1'b1, 8'h33);

    // T1: lock onto 01..09
    for (int k = 1; k <= 7; k += 2) stepc("t1", 1, k);
    check("t1.not_locked_yet", 32'(locked_o), 32'd0);
    stepc("t1", 1, 9);
    check("t1.locked", 32'(locked_o), 32'd1);
    check("t1.exp", 32'(exp_o), 32'h0B);
    check("t1.err_cnt", 32'(err_cnt_o), 32'd0);

    // T2: wrap through FF -> 01
    for (int k = 'h0B; k <= 'hFF; k += 2) stepc("t2", 1, k);
    for (int k = 1; k <= 3; k += 2) stepc("t2", 1, k);
    check("t2.locked", 32'(locked_o), 32'd1);
    check("t2.exp", 32'(exp_o), 32'h05);
    check("t2.err_cnt", 32'(err_cnt_o), 32'd0);

    // T3: single glitch
    for (int k = 5; k <= 'h0F; k += 2) stepc("t3", 1, k);
    stepc("t3", 1, 'h15);
    check("t3.err_pulse", 32'(err_o), 32'd1);
    stepc("t3", 1, 'h17);
    check("t3.err_done", 32'(err_o), 32'd0);
    check("t3.err_cnt", 32'(err_cnt_o), 32'd1);
    check("t3.locked", 32'(locked_o), 32'd1);

    // T4: two consecutive misses drop lock
    for (int k = 'h19; k <= 'h1F; k += 2) stepc("t4", 1, k);
    stepc("t4", 1, 'h31);
    stepc("t4", 1, 'h41);
    check("t4.unlocked", 32'(locked_o), 32'd0);
    check("t4.err_cnt", 32'(err_cnt_o), 32'd3);
    stepc("t4.reanchor", 1, 'h51);
    check("t4.exp", 32'(exp_o), 32'h53);

    // T5: parity error in HUNT, then lock with gaps
    applyReset(1'b0, 0);
    stepc("t5", 1, 'h04);
    check("t5.parity", 32'(parity_err_o), 32'd1);
    check("t5.exp", 32'(exp_o), 32'd1);
    for (int k = 1; k <= 9; k += 2) begin
      r = $urandom_range(0, 3);
      for (int g = 0; g < r; g++) stepc("t5.gap", 0, $urandom_range(0, 255));
      stepc("t5", 1, k);
    end
    check("t5.locked", 32'(locked_o), 32'd1);
    check("t5.exp_lock", 32'(exp_o), 32'h0B);

    // T6: three isolated errors, saturation on the narrow copy, reset mid-op
    stepc("t6", 1, 'h21); stepc("t6", 1, 'h23);
    stepc("t6", 1, 'h31); stepc("t6", 1, 'h33);
    stepc("t6", 1, 'h41); stepc("t6", 1, 'h43);
    check("t6.err_cnt3", 32'(err_cnt_o), 32'd3);
    check("t6.locked", 32'(locked_o), 32'd1);
    stepc("t6", 1, 'h61); stepc("t6", 1, 'h63);
    check("t6.sat", 32'(err_cnt2), 32'd3);
    check("t6.err_cnt4", 32'(err_cnt_o), 32'd4);
    applyReset(1'b1, 'h65);
    check("t6.rst_cnt", 32'(err_cnt_o), 32'd0);
    check("t6.rst_exp", 32'(exp_o), 32'd1);

    // Random traffic biased toward the expected value
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        applyReset($urandom_range(0, 1) == 1, $urandom_range(0, 255));
      end else begin
        v = $urandom_range(0, 3) != 0;
        r = $urandom_range(0, 9);
        if (r < 7)      c = m_exp;
        else if (r < 9) c = 2 * $urandom_range(0, 127) + 1;
        else            c = 2 * $urandom_range(0, 127);
        stepc("rand", v, c);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
